// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the hazard scoreboard: the in-flight destination tag slot,
// its bubble value and the source-operand match helpers.
package hazard_scoreboard_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [4:0] dest;
        logic       reg_write;
        logic       mem_read;
    } tag_slot_t;

    localparam int unsigned SLOT_W = $bits(tag_slot_t);
    localparam tag_slot_t   BUBBLE = '0;

    // $zero is never a real producer, so a dest of 0 cannot match.
    function automatic logic slot_match(tag_slot_t s, logic [4:0] r);
        return s.reg_write && (s.dest != REG_ZERO) && (s.dest == r);
    endfunction

    function automatic logic src_hit(tag_slot_t s, logic valid, logic [4:0] rs, logic [4:0] rt,
                                     logic rs_used, logic rt_used);
        return valid && ((rs_used && slot_match(s, rs)) || (rt_used && slot_match(s, rt)));
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage request signals and the forwarding/stall outputs of the scoreboard.
interface hazard_scoreboard_if #(
    parameter int unsigned CNT_W = 16
);
    logic             id_valid;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_rs_used;
    logic             id_rt_used;
    logic [4:0]       id_dest;
    logic             id_reg_write;
    logic             id_mem_read;
    logic             id_br_taken;
    logic             stall;
    logic             if_flush;
    logic [4:0]       ex_dest;
    logic             ex_mem_read;
    logic [4:0]       mem_dest;
    logic             mem_reg_write;
    logic [4:0]       wb_dest;
    logic             wb_reg_write;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_dest, id_reg_write,
               id_mem_read, id_br_taken,
        input  stall, if_flush, ex_dest, ex_mem_read, mem_dest, mem_reg_write, wb_dest,
               wb_reg_write, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_dest, id_reg_write,
               id_mem_read, id_br_taken,
        output stall, if_flush, ex_dest, ex_mem_read, mem_dest, mem_reg_write, wb_dest,
               wb_reg_write, stall_cnt
    );

endinterface

// File: rtl/hazard_tag_stage.sv
// One registered pipeline tag slot; bubble forces the captured value to all zero.
module hazard_tag_stage
    import hazard_scoreboard_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      bubble,
    input  tag_slot_t slot_d,
    output tag_slot_t slot_q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q <= BUBBLE;
        end else begin
            slot_q <= bubble ? BUBBLE : slot_d;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks destination tags through EX/MEM/WB, detects load-use and regfile RAW
// hazards in ID, and generates stall, branch flush and a saturating stall count.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter bit          MEM_FWD          = 1'b1,
    parameter bit          RF_WRITE_THROUGH = 1'b1,
    parameter int unsigned CNT_W            = 16
) (
    input logic                clk,
    input logic                rst,
    hazard_scoreboard_if.slave bus
);

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    tag_slot_t        id_slot;
    tag_slot_t        ex_slot;
    tag_slot_t        mem_slot;
    tag_slot_t        wb_slot;
    logic             ex_hit;
    logic             mem_hit;
    logic             wb_hit;
    logic             stall;
    logic             ex_bubble;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             unused_wb_mem_read;

    assign id_slot = '{dest: bus.id_dest, reg_write: bus.id_reg_write,
                       mem_read: bus.id_mem_read};

    always_comb begin
        ex_hit  = src_hit(ex_slot, bus.id_valid, bus.id_rs, bus.id_rt,
                          bus.id_rs_used, bus.id_rt_used);
        mem_hit = src_hit(mem_slot, bus.id_valid, bus.id_rs, bus.id_rt,
                          bus.id_rs_used, bus.id_rt_used);
        wb_hit  = src_hit(wb_slot, bus.id_valid, bus.id_rs, bus.id_rt,
                          bus.id_rs_used, bus.id_rt_used);
    end

    // Non-load EX/MEM hits are covered by forwarding; only a load result that
    // is not yet forwardable, or a WB write not visible to the read, stalls.
    assign stall = (ex_hit && ex_slot.mem_read)
                 || (!MEM_FWD && mem_hit && mem_slot.mem_read)
                 || (!RF_WRITE_THROUGH && wb_hit);

    assign ex_bubble = stall || !bus.id_valid;

    hazard_tag_stage u_ex_stage (
        .clk    (clk),
        .rst    (rst),
        .bubble (ex_bubble),
        .slot_d (id_slot),
        .slot_q (ex_slot)
    );

    hazard_tag_stage u_mem_stage (
        .clk    (clk),
        .rst    (rst),
        .bubble (1'b0),
        .slot_d (ex_slot),
        .slot_q (mem_slot)
    );

    hazard_tag_stage u_wb_stage (
        .clk    (clk),
        .rst    (rst),
        .bubble (1'b0),
        .slot_d (mem_slot),
        .slot_q (wb_slot)
    );

    always_comb begin
        cnt_d = cnt_q;
        if (stall && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + CntOne;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A stalled branch keeps its flush until it re-resolves unstalled.
    assign bus.if_flush      = bus.id_br_taken && !stall;
    assign bus.stall         = stall;
    assign bus.ex_dest       = ex_slot.dest;
    assign bus.ex_mem_read   = ex_slot.mem_read;
    assign bus.mem_dest      = mem_slot.dest;
    assign bus.mem_reg_write = mem_slot.reg_write;
    assign bus.wb_dest       = wb_slot.dest;
    assign bus.wb_reg_write  = wb_slot.reg_write;
    assign bus.stall_cnt     = cnt_q;

    assign unused_wb_mem_read = wb_slot.mem_read;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: three parameterisations driven by the same ID
// stream and checked every cycle against a per-configuration reference model.
module tb_hazard_scoreboard;

    typedef struct {
        int dest;
        bit rw;
        bit mr;
    } ent_t;

    typedef struct packed {
        logic        stall;
        logic        if_flush;
        logic [4:0]  ex_dest;
        logic        ex_mem_read;
        logic [4:0]  mem_dest;
        logic        mem_reg_write;
        logic [4:0]  wb_dest;
        logic        wb_reg_write;
        logic [15:0] cnt;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    always #10 clk = ~clk;

    logic       s_valid, s_rs_used, s_rt_used, s_rw, s_mr, s_br;
    logic [4:0] s_rs, s_rt, s_dest;

    hazard_scoreboard_if #(.CNT_W(16)) bus0 ();
    hazard_scoreboard_if #(.CNT_W(16)) bus1 ();
    hazard_scoreboard_if #(.CNT_W(2))  bus2 ();

    assign bus0.id_valid = s_valid, bus0.id_rs = s_rs, bus0.id_rt = s_rt,
           bus0.id_rs_used = s_rs_used, bus0.id_rt_used = s_rt_used, bus0.id_dest = s_dest,
           bus0.id_reg_write = s_rw, bus0.id_mem_read = s_mr, bus0.id_br_taken = s_br;
    assign bus1.id_valid = s_valid, bus1.id_rs = s_rs, bus1.id_rt = s_rt,
           bus1.id_rs_used = s_rs_used, bus1.id_rt_used = s_rt_used, bus1.id_dest = s_dest,
           bus1.id_reg_write = s_rw, bus1.id_mem_read = s_mr, bus1.id_br_taken = s_br;
    assign bus2.id_valid = s_valid, bus2.id_rs = s_rs, bus2.id_rt = s_rt,
           bus2.id_rs_used = s_rs_used, bus2.id_rt_used = s_rt_used, bus2.id_dest = s_dest,
           bus2.id_reg_write = s_rw, bus2.id_mem_read = s_mr, bus2.id_br_taken = s_br;

    hazard_scoreboard u0 (.clk(clk), .rst(rst), .bus(bus0));
    hazard_scoreboard #(.MEM_FWD(1'b0), .RF_WRITE_THROUGH(1'b0), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .bus(bus1));
    hazard_scoreboard #(.MEM_FWD(1'b1), .RF_WRITE_THROUGH(1'b0), .CNT_W(2)) u2 (
        .clk(clk), .rst(rst), .bus(bus2));

    obs_t obs [3];
    always_comb begin
        obs[0] = '{bus0.stall, bus0.if_flush, bus0.ex_dest, bus0.ex_mem_read, bus0.mem_dest,
                   bus0.mem_reg_write, bus0.wb_dest, bus0.wb_reg_write, bus0.stall_cnt};
        obs[1] = '{bus1.stall, bus1.if_flush, bus1.ex_dest, bus1.ex_mem_read, bus1.mem_dest,
                   bus1.mem_reg_write, bus1.wb_dest, bus1.wb_reg_write, bus1.stall_cnt};
        obs[2] = '{bus2.stall, bus2.if_flush, bus2.ex_dest, bus2.ex_mem_read, bus2.mem_dest,
                   bus2.mem_reg_write, bus2.wb_dest, bus2.wb_reg_write, 16'(bus2.stall_cnt)};
    end

    // Reference model: age 0 = EX, 1 = MEM, 2 = WB.
    bit   cfg_mem_fwd [3] = '{1'b1, 1'b0, 1'b1};
    bit   cfg_rf_wt   [3] = '{1'b1, 1'b0, 1'b0};
    int   cfg_max     [3] = '{65535, 65535, 3};
    ent_t pipe [3][3];
    int   cnt  [3];
    bit   m_stall [3];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_stall(int c);
        bit s;
        bit reads;
        bit hz;
        s = 1'b0;
        for (int k = 0; k < 3; k++) begin
            reads = (s_rs_used && (32'(s_rs) == pipe[c][k].dest))
                 || (s_rt_used && (32'(s_rt) == pipe[c][k].dest));
            hz = s_valid && pipe[c][k].rw && (pipe[c][k].dest != 0) && reads;
            if (hz && ((k == 0 && pipe[c][k].mr)
                    || (k == 1 && pipe[c][k].mr && !cfg_mem_fwd[c])
                    || (k == 2 && !cfg_rf_wt[c]))) begin
                s = 1'b1;
            end
        end
        return s;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            cnt[c] = 0;
            for (int k = 0; k < 3; k++) pipe[c][k] = '{0, 1'b0, 1'b0};
        end
    endtask

    task automatic drive(input bit v, input logic [4:0] rs, input logic [4:0] rt,
                         input bit rsu, input bit rtu, input logic [4:0] dest,
                         input bit rw, input bit mr, input bit br);
        s_valid = v; s_rs = rs; s_rt = rt; s_rs_used = rsu; s_rt_used = rtu;
        s_dest = dest; s_rw = rw; s_mr = mr; s_br = br;
        #1;
    endtask

    // Compare every observable against the model, then clock and advance it.
    task automatic step();
        #1;
        for (int c = 0; c < 3; c++) begin
            m_stall[c] = model_stall(c);
            check_eq($sformatf("c%0d stall", c), 32'(obs[c].stall), 32'(m_stall[c]));
            check_eq($sformatf("c%0d if_flush", c), 32'(obs[c].if_flush),
                     32'(s_br && !m_stall[c]));
            check_eq($sformatf("c%0d ex_dest", c), 32'(obs[c].ex_dest), pipe[c][0].dest);
            check_eq($sformatf("c%0d ex_mem_read", c), 32'(obs[c].ex_mem_read),
                     32'(pipe[c][0].mr));
            check_eq($sformatf("c%0d mem_dest", c), 32'(obs[c].mem_dest), pipe[c][1].dest);
            check_eq($sformatf("c%0d mem_reg_write", c), 32'(obs[c].mem_reg_write),
                     32'(pipe[c][1].rw));
            check_eq($sformatf("c%0d wb_dest", c), 32'(obs[c].wb_dest), pipe[c][2].dest);
            check_eq($sformatf("c%0d wb_reg_write", c), 32'(obs[c].wb_reg_write),
                     32'(pipe[c][2].rw));
            check_eq($sformatf("c%0d stall_cnt", c), 32'(obs[c].cnt), cnt[c]);
        end
        @(posedge clk);
        for (int c = 0; c < 3; c++) begin
            pipe[c][2] = pipe[c][1];
            pipe[c][1] = pipe[c][0];
            if (m_stall[c] || !s_valid) pipe[c][0] = '{0, 1'b0, 1'b0};
            else                        pipe[c][0] = '{int'(s_dest), s_rw, s_mr};
            if (m_stall[c] && cnt[c] < cfg_max[c]) cnt[c]++;
        end
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
            step();
        end
    endtask

    task automatic load_use(input logic [4:0] d, input int hold);
        drive(1, 0, 0, 0, 0, d, 1, 1, 0);
        step();
        repeat (hold) begin
            drive(1, d, 0, 1, 0, 5'd10, 1, 0, 0);
            step();
        end
        idle(4);
    endtask

    initial begin
        rst = 1'b1;
        model_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check_eq("rst stall", 32'(obs[0].stall), 0);
        check_eq("rst mem_reg_write", 32'(obs[0].mem_reg_write), 0);
        check_eq("rst stall_cnt", 32'(obs[0].cnt), 0);
        rst = 1'b0;
        idle(2);

        // Load-use: lw $8 then a reader of rs=8 held in ID for four cycles.
        drive(1, 0, 0, 0, 0, 5'd8, 1, 1, 0);
        step();
        drive(1, 5'd8, 0, 1, 0, 5'd10, 1, 0, 0);
        check_eq("lu c0 stall", 32'(obs[0].stall), 1);
        check_eq("lu c1 stall", 32'(obs[1].stall), 1);
        check_eq("lu c0 ex_dest", 32'(obs[0].ex_dest), 8);
        step();
        drive(1, 5'd8, 0, 1, 0, 5'd10, 1, 0, 0);
        check_eq("lu c0 unstall", 32'(obs[0].stall), 0);
        check_eq("lu c0 bubble", 32'(obs[0].ex_dest), 0);
        check_eq("lu c0 mem_dest", 32'(obs[0].mem_dest), 8);
        check_eq("lu c0 mem_rw", 32'(obs[0].mem_reg_write), 1);
        check_eq("lu c0 cnt", 32'(obs[0].cnt), 1);
        check_eq("lu c1 stall2", 32'(obs[1].stall), 1);
        step();
        drive(1, 5'd8, 0, 1, 0, 5'd10, 1, 0, 0);
        check_eq("lu c1 stall3", 32'(obs[1].stall), 1);
        step();
        drive(1, 5'd8, 0, 1, 0, 5'd10, 1, 0, 0);
        check_eq("lu c1 unstall", 32'(obs[1].stall), 0);
        check_eq("lu c1 cnt", 32'(obs[1].cnt), 3);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_eq("lu c1 consumer in ex", 32'(obs[1].ex_dest), 10);
        step();
        idle(3);

        // ALU dependency is forwarded.
        drive(1, 0, 0, 0, 0, 5'd9, 1, 0, 0);
        step();
        drive(1, 0, 5'd9, 0, 1, 5'd11, 1, 0, 0);
        check_eq("alu c0 stall", 32'(obs[0].stall), 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_eq("alu mem_dest", 32'(obs[0].mem_dest), 9);
        check_eq("alu mem_rw", 32'(obs[0].mem_reg_write), 1);
        step();
        idle(3);

        // Load into $zero never hazards but still travels down the pipe.
        drive(1, 0, 0, 0, 0, 0, 1, 1, 0);
        step();
        drive(1, 0, 0, 1, 0, 5'd12, 1, 0, 0);
        check_eq("zero c0 stall", 32'(obs[0].stall), 0);
        check_eq("zero c1 stall", 32'(obs[1].stall), 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_eq("zero mem_rw", 32'(obs[0].mem_reg_write), 1);
        check_eq("zero mem_dest", 32'(obs[0].mem_dest), 0);
        step();
        idle(3);

        // Taken branch during a load-use stall: flush is deferred one cycle.
        drive(1, 0, 0, 0, 0, 5'd8, 1, 1, 0);
        step();
        drive(1, 5'd8, 0, 1, 0, 5'd10, 1, 0, 1);
        check_eq("br stall", 32'(obs[0].stall), 1);
        check_eq("br no flush", 32'(obs[0].if_flush), 0);
        step();
        drive(1, 5'd8, 0, 1, 0, 5'd10, 1, 0, 1);
        check_eq("br flush", 32'(obs[0].if_flush), 1);
        check_eq("br unstall", 32'(obs[0].stall), 0);
        step();
        idle(4);

        // Two more hazards take c2 past its 2-bit limit.
        load_use(5'd6, 4);
        load_use(5'd7, 4);
        check_eq("sat c2 cnt", 32'(obs[2].cnt), 3);

        // Asynchronous reset in the middle of a stall.
        drive(1, 0, 0, 0, 0, 5'd7, 1, 0, 0);
        step();
        drive(1, 0, 0, 0, 0, 5'd8, 1, 1, 0);
        step();
        drive(1, 5'd8, 0, 1, 0, 5'd10, 1, 0, 1);
        check_eq("ar pre stall", 32'(obs[0].stall), 1);
        check_eq("ar pre mem_rw", 32'(obs[0].mem_reg_write), 1);
        #1 rst = 1'b1;
        #1;
        for (int c = 0; c < 3; c++) begin
            check_eq($sformatf("ar c%0d stall", c), 32'(obs[c].stall), 0);
            check_eq($sformatf("ar c%0d mem_rw", c), 32'(obs[c].mem_reg_write), 0);
            check_eq($sformatf("ar c%0d wb_rw", c), 32'(obs[c].wb_reg_write), 0);
            check_eq($sformatf("ar c%0d cnt", c), 32'(obs[c].cnt), 0);
        end
        model_reset();
        rst = 1'b0;
        #1;
        check_eq("ar post flush", 32'(obs[0].if_flush), 1);
        check_eq("ar post stall", 32'(obs[0].stall), 0);
        step();
        idle(3);

        // Random stream over a small register set to provoke frequent hits.
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 9) != 0, 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                  5'($urandom_range(0, 3)), 1'($urandom), $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b1;
                #1;
                model_reset();
                rst = 1'b0;
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
